// File: rtl/muldiv_issue_pkg.sv
// Shared types and constants for the MulDiv issue unit.
//   md_state_e  : issue FSM states
//   FN_*        : MulDiv function codes
//   md_result_t : one completed result (data, tag, cycle count). Fields are
//                 sized for the widest supported TAG_W/CNT_W; narrower
//                 instances use the low bits.
package muldiv_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } md_state_e;

  localparam logic [3:0] FN_MUL    = 4'd0;
  localparam logic [3:0] FN_MULH   = 4'd1;
  localparam logic [3:0] FN_MULHSU = 4'd2;
  localparam logic [3:0] FN_MULHU  = 4'd3;
  localparam logic [3:0] FN_DIV    = 4'd4;
  localparam logic [3:0] FN_DIVU   = 4'd5;
  localparam logic [3:0] FN_REM    = 4'd6;
  localparam logic [3:0] FN_REMU   = 4'd7;

  localparam int MAX_TAG_W = 16;
  localparam int MAX_CNT_W = 32;

  typedef struct packed {
    logic [63:0]          data;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_CNT_W-1:0] cycles;
  } md_result_t;

endpackage

// File: rtl/muldiv_result_fifo.sv
// Small synchronous FIFO holding completed MulDiv results.
//   clock, reset       : clock, asynchronous active-high reset (empties FIFO)
//   wr_en, wr_data     : enqueue request and entry (ignored when full)
//   rd_en              : dequeue the head entry (ignored when empty)
//   rd_data            : head entry, combinational from storage
//   full, empty        : occupancy flags
// DEPTH must be a power of two; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the indices match.
module muldiv_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Storage is cleared too so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/muldiv_issue_unit.sv
// Request-side driver for the MulDiv unit: takes one op at a time from the
// issue queue, presents it to MulDiv, waits for the response and pushes
// {data, tag, latency} into an output FIFO.
//   clock, reset              : clock, asynchronous active-high reset
//   io_in_*                   : upstream valid/ready op (fn, dw, in1, in2, tag)
//   io_flush                  : abandon the in-flight op
//   io_md_req_*               : MulDiv request channel
//   io_md_kill                : MulDiv kill pulse (flush while busy)
//   io_md_resp_*              : MulDiv response channel
//   io_out_*                  : downstream results (data, tag, cycles)
module muldiv_issue_unit
  import muldiv_issue_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int CNT_W     = 8,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [3:0]       io_in_bits_fn,
  input  logic             io_in_bits_dw,
  input  logic [63:0]      io_in_bits_in1,
  input  logic [63:0]      io_in_bits_in2,
  input  logic [TAG_W-1:0] io_in_bits_tag,
  input  logic             io_flush,
  output logic             io_md_req_valid,
  input  logic             io_md_req_ready,
  output logic [3:0]       io_md_req_bits_fn,
  output logic             io_md_req_bits_dw,
  output logic [63:0]      io_md_req_bits_in1,
  output logic [63:0]      io_md_req_bits_in2,
  output logic             io_md_kill,
  output logic             io_md_resp_ready,
  input  logic             io_md_resp_valid,
  input  logic [63:0]      io_md_resp_bits_data,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [63:0]      io_out_bits_data,
  output logic [TAG_W-1:0] io_out_bits_tag,
  output logic [CNT_W-1:0] io_out_bits_cycles
);

  localparam int ENTRY_W = 64 + TAG_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  md_state_e        state_q, state_d;
  logic [3:0]       fn_q, fn_d;
  logic             dw_q, dw_d;
  logic [63:0]      in1_q, in1_d;
  logic [63:0]      in2_q, in2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               fifo_wr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic [ENTRY_W-1:0] fifo_rd_data;

  assign io_md_req_bits_fn  = fn_q;
  assign io_md_req_bits_dw  = dw_q;
  assign io_md_req_bits_in1 = in1_q;
  assign io_md_req_bits_in2 = in2_q;
  assign io_out_valid       = !fifo_empty;
  assign {io_out_bits_data, io_out_bits_tag, io_out_bits_cycles} = fifo_rd_data;

  always_comb begin
    state_d          = state_q;
    fn_d             = fn_q;
    dw_d             = dw_q;
    in1_d            = in1_q;
    in2_d            = in2_q;
    tag_d            = tag_q;
    cnt_d            = cnt_q;
    io_in_ready      = 1'b0;
    io_md_req_valid  = 1'b0;
    io_md_kill       = 1'b0;
    io_md_resp_ready = 1'b0;
    fifo_wr          = 1'b0;
    accept           = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A free FIFO slot is reserved at accept time, so the eventual
        // response can always be enqueued regardless of io_out_ready.
        io_in_ready = !fifo_full && !io_flush && !reset;
        accept      = io_in_valid && io_in_ready;
        if (accept) begin
          fn_d    = io_in_bits_fn;
          dw_d    = io_in_bits_dw;
          in1_d   = io_in_bits_in1;
          in2_d   = io_in_bits_in2;
          tag_d   = io_in_bits_tag;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // MulDiv has not taken the op yet, so a flush needs no kill.
        if (io_flush) begin
          state_d = IDLE;
        end else begin
          io_md_req_valid = 1'b1;
          cnt_d           = sat_inc(cnt_q);
          if (io_md_req_ready) state_d = BUSY;
        end
      end
      BUSY: begin
        if (io_flush) begin
          io_md_kill = 1'b1;
          state_d    = IDLE;
        end else begin
          io_md_resp_ready = 1'b1;
          cnt_d            = sat_inc(cnt_q);
          if (io_md_resp_valid) begin
            fifo_wr = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fn_q    <= '0;
      dw_q    <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      dw_q    <= dw_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  // The stored count includes the response cycle itself.
  muldiv_result_fifo #(
    .DEPTH(OUT_DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (fifo_wr),
    .wr_data({io_md_resp_bits_data, tag_q, sat_inc(cnt_q)}),
    .rd_en  (io_out_valid && io_out_ready),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_muldiv_issue_unit.sv
module tb_muldiv_issue_unit;
  import muldiv_issue_pkg::*;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid, io_in_ready;
  logic [3:0]       io_in_bits_fn;
  logic             io_in_bits_dw;
  logic [63:0]      io_in_bits_in1, io_in_bits_in2;
  logic [TAG_W-1:0] io_in_bits_tag;
  logic             io_flush;
  logic             io_md_req_valid, io_md_req_ready;
  logic [3:0]       io_md_req_bits_fn;
  logic             io_md_req_bits_dw;
  logic [63:0]      io_md_req_bits_in1, io_md_req_bits_in2;
  logic             io_md_kill, io_md_resp_ready, io_md_resp_valid;
  logic [63:0]      io_md_resp_bits_data;
  logic             io_out_valid, io_out_ready;
  logic [63:0]      io_out_bits_data;
  logic [TAG_W-1:0] io_out_bits_tag;
  logic [CNT_W-1:0] io_out_bits_cycles;

  muldiv_issue_unit #(.TAG_W(TAG_W), .CNT_W(CNT_W), .OUT_DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_fn(io_in_bits_fn), .io_in_bits_dw(io_in_bits_dw),
    .io_in_bits_in1(io_in_bits_in1), .io_in_bits_in2(io_in_bits_in2),
    .io_in_bits_tag(io_in_bits_tag), .io_flush(io_flush),
    .io_md_req_valid(io_md_req_valid), .io_md_req_ready(io_md_req_ready),
    .io_md_req_bits_fn(io_md_req_bits_fn), .io_md_req_bits_dw(io_md_req_bits_dw),
    .io_md_req_bits_in1(io_md_req_bits_in1), .io_md_req_bits_in2(io_md_req_bits_in2),
    .io_md_kill(io_md_kill), .io_md_resp_ready(io_md_resp_ready),
    .io_md_resp_valid(io_md_resp_valid), .io_md_resp_bits_data(io_md_resp_bits_data),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_data(io_out_bits_data), .io_out_bits_tag(io_out_bits_tag),
    .io_out_bits_cycles(io_out_bits_cycles)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  bit         rand_out = 1'b0;
  md_result_t sb[$];
  md_result_t mon_e;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every output handshake pops the oldest expectation.
  always @(negedge clock) begin
    if (!reset && io_out_valid && io_out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got entry tag %0d, expected no entry", io_out_bits_tag);
      end else begin
        mon_e = sb.pop_front();
        chk64("out_data", io_out_bits_data, mon_e.data);
        chk64("out_tag", 64'(io_out_bits_tag), 64'(mon_e.tag[TAG_W-1:0]));
        chk64("out_cycles", 64'(io_out_bits_cycles), 64'(mon_e.cycles[CNT_W-1:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_out) io_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input logic [3:0] fn, input logic dw, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] tag, output bit ok);
    int n;
    tick();
    io_in_valid = 1'b1;
    io_in_bits_fn = fn; io_in_bits_dw = dw;
    io_in_bits_in1 = a; io_in_bits_in2 = b; io_in_bits_tag = tag;
    #1;
    n = 0;
    while (!io_in_ready && n < 300) begin
      tick();
      #1;
      n++;
    end
    ok = io_in_ready;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected accept", n);
      io_in_valid = 1'b0;
    end
  endtask

  task automatic chk_req(input logic [3:0] fn, input logic dw, input logic [63:0] a,
                         input logic [63:0] b);
    chk1("req_valid", io_md_req_valid, 1'b1);
    chk64("req_fn", 64'(io_md_req_bits_fn), 64'(fn));
    chk1("req_dw", io_md_req_bits_dw, dw);
    chk64("req_in1", io_md_req_bits_in1, a);
    chk64("req_in2", io_md_req_bits_in2, b);
  endtask

  // Plays MulDiv for one accepted op. fmode: 0 normal, 1 flush in REQ,
  // 2 flush in BUSY coincident with the response.
  task automatic complete(input logic [3:0] fn, input logic dw, input logic [63:0] a,
                          input logic [63:0] b, input logic [TAG_W-1:0] tag,
                          input int stall, input int lat, input logic [63:0] data,
                          input int fmode, input bit strict);
    md_result_t e;
    int ecyc;
    tick();
    io_in_valid = 1'b0;
    if (fmode == 1) begin
      io_flush = 1'b1;
      #1;
      chk1("flush_req_valid", io_md_req_valid, 1'b0);
      chk1("flush_req_kill", io_md_kill, 1'b0);
      tick();
      io_flush = 1'b0;
      #1;
      chk1("flush_req_idle", io_md_req_valid, 1'b0);
      if (strict) chk1("flush_req_in_ready", io_in_ready, 1'b1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      io_md_req_ready = 1'b0;
      #1;
      chk_req(fn, dw, a, b);
      tick();
    end
    io_md_req_ready = 1'b1;
    #1;
    chk_req(fn, dw, a, b);
    tick();
    io_md_req_ready = 1'b0;
    for (int l = 1; l < lat; l++) begin
      #1;
      chk1("busy_resp_ready", io_md_resp_ready, 1'b1);
      tick();
    end
    io_md_resp_valid = 1'b1;
    io_md_resp_bits_data = data;
    if (fmode == 2) begin
      io_flush = 1'b1;
      #1;
      chk1("flush_busy_kill", io_md_kill, 1'b1);
      chk1("flush_busy_resp_ready", io_md_resp_ready, 1'b0);
      tick();
      io_flush = 1'b0;
      io_md_resp_valid = 1'b0;
      #1;
      chk1("flush_busy_idle", io_md_req_valid, 1'b0);
      if (strict) begin
        chk1("flush_busy_in_ready", io_in_ready, 1'b1);
        chk1("flush_busy_no_entry", io_out_valid, 1'b0);
      end
      return;
    end
    #1;
    chk1("resp_ready", io_md_resp_ready, 1'b1);
    chk1("no_kill", io_md_kill, 1'b0);
    ecyc = 1 + stall + lat;
    if (ecyc > CMAX) ecyc = CMAX;
    e.data   = data;
    e.tag    = MAX_TAG_W'(tag);
    e.cycles = MAX_CNT_W'(ecyc);
    sb.push_back(e);
    tick();
    io_md_resp_valid = 1'b0;
    #1;
    if (strict) chk1("out_visible", io_out_valid, 1'b1);
  endtask

  task automatic run_op(input logic [3:0] fn, input logic dw, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] tag,
                        input int stall, input int lat, input logic [63:0] data,
                        input int fmode, input bit strict);
    bit ok;
    issue(fn, dw, a, b, tag, ok);
    if (ok) complete(fn, dw, a, b, tag, stall, lat, data, fmode, strict);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int n;
    logic [63:0] a, b, d;
    logic [3:0]  fn;
    int fsel;
    reset = 1'b1;
    io_in_valid = 1'b0; io_in_bits_fn = '0; io_in_bits_dw = 1'b0;
    io_in_bits_in1 = '0; io_in_bits_in2 = '0; io_in_bits_tag = '0;
    io_flush = 1'b0; io_md_req_ready = 1'b0; io_md_resp_valid = 1'b0;
    io_md_resp_bits_data = '0; io_out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk1("rst_in_ready", io_in_ready, 1'b0);
    chk1("rst_req_valid", io_md_req_valid, 1'b0);
    chk1("rst_kill", io_md_kill, 1'b0);
    chk1("rst_resp_ready", io_md_resp_ready, 1'b0);
    chk1("rst_out_valid", io_out_valid, 1'b0);
    chk64("rst_req_in1", io_md_req_bits_in1, 64'd0);
    chk64("rst_out_data", io_out_bits_data, 64'd0);
    reset = 1'b0;
    #1;
    chk1("post_rst_in_ready", io_in_ready, 1'b1);

    // Basic MUL, response 2 cycles after request fire.
    io_out_ready = 1'b1;
    run_op(FN_MUL, 1'b1, 64'd6, 64'd7, 4'd3, 0, 2, 64'd42, 0, 1'b1);
    tick();
    #1;
    chk1("basic_one_entry", io_out_valid, 1'b0);

    // Request back-pressure for 5 cycles.
    run_op(FN_DIV, 1'b1, 64'd100, 64'd7, 4'd5, 5, 3, 64'd14, 0, 1'b1);

    // Flush in BUSY with a coincident response, then flush in REQ.
    run_op(FN_REM, 1'b0, 64'd9, 64'd4, 4'd9, 0, 3, 64'd1, 2, 1'b1);
    run_op(FN_DIVU, 1'b0, 64'd8, 64'd2, 4'd10, 0, 2, 64'd4, 1, 1'b1);

    // FIFO full: two results held, third op waits for a slot.
    io_out_ready = 1'b0;
    run_op(FN_MULH, 1'b1, 64'd11, 64'd12, 4'd1, 0, 1, 64'h1111, 0, 1'b1);
    run_op(FN_MULHSU, 1'b1, 64'd13, 64'd14, 4'd2, 1, 2, 64'h2222, 0, 1'b1);
    tick();
    io_in_valid = 1'b1;
    io_in_bits_fn = FN_REMU; io_in_bits_dw = 1'b0;
    io_in_bits_in1 = 64'd15; io_in_bits_in2 = 64'd16; io_in_bits_tag = 4'd4;
    #1;
    chk1("full_in_ready", io_in_ready, 1'b0);
    repeat (3) begin
      tick();
      #1;
      chk1("full_in_ready_hold", io_in_ready, 1'b0);
    end
    tick();
    io_out_ready = 1'b1;
    #1;
    chk1("full_pop_cycle_in_ready", io_in_ready, 1'b0);
    tick();
    io_out_ready = 1'b0;
    #1;
    chk1("third_accept", io_in_ready, 1'b1);
    complete(FN_REMU, 1'b0, 64'd15, 64'd16, 4'd4, 0, 2, 64'h4444, 0, 1'b1);
    io_out_ready = 1'b1;
    repeat (4) tick();
    chk64("full_drained", 64'(sb.size()), 64'd0);

    // Saturation of the 4-bit counter.
    run_op(FN_MULHU, 1'b1, 64'd3, 64'd5, 4'd7, 0, 40, 64'h5555, 0, 1'b1);

    // Randomised ops with random downstream readiness and occasional flushes.
    rand_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      fn = 4'($urandom_range(0, 7));
      d = (fn == FN_MUL) ? a * b : {$urandom, $urandom};
      fsel = $urandom_range(0, 5);
      run_op(fn, 1'($urandom_range(0, 1)), a, b, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(1, 20), d,
             (fsel == 4) ? 1 : (fsel == 5) ? 2 : 0, 1'b0);
    end
    rand_out = 1'b0;
    io_out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk64("random_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset while BUSY with a result waiting in the FIFO.
    io_out_ready = 1'b0;
    run_op(FN_MUL, 1'b1, 64'd2, 64'd3, 4'd6, 0, 1, 64'd6, 0, 1'b1);
    issue(FN_DIV, 1'b1, 64'd20, 64'd5, 4'd8, ok);
    tick();
    io_in_valid = 1'b0;
    io_md_req_ready = 1'b1;
    tick();
    io_md_req_ready = 1'b0;
    #1;
    chk1("pre_rst_busy", io_md_resp_ready, 1'b1);
    chk1("pre_rst_out_valid", io_out_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk1("midrst_resp_ready", io_md_resp_ready, 1'b0);
    chk1("midrst_out_valid", io_out_valid, 1'b0);
    chk1("midrst_kill", io_md_kill, 1'b0);
    sb.delete();
    tick();
    reset = 1'b0;
    #1;
    chk1("after_rst_in_ready", io_in_ready, 1'b1);
    chk1("after_rst_out_valid", io_out_valid, 1'b0);
    chk1("after_rst_req_valid", io_md_req_valid, 1'b0);
    io_out_ready = 1'b1;
    run_op(FN_MUL, 1'b1, 64'd6, 64'd7, 4'd3, 0, 2, 64'd42, 0, 1'b1);
    repeat (3) tick();
    chk64("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_unit.md
# muldiv_issue_unit

Request-side driver for the MulDiv functional unit. Accepts one operation at a time from an upstream valid/ready queue, registers it, and drives the MulDiv request/kill/response-ready pins. It collects the result together with the op tag and a measured cycle count into a small output FIFO. It sits between the issue stage and MulDiv, and serves as the standard stimulus/consumer harness for MulDiv timing-independence checks.

## Interface
Parameters:
- TAG_W, 4, width of the op tag carried alongside each operation
- CNT_W, 8, width of the saturating latency counter
- OUT_DEPTH, 2, output FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- io_in_valid / io_in_ready  in / out  1 / 1  upstream handshake
- io_in_bits_fn  in  4  MulDiv function code
- io_in_bits_dw  in  1  data width select (1 = 64-bit, 0 = 32-bit)
- io_in_bits_in1, io_in_bits_in2  in  64  operands
- io_in_bits_tag  in  TAG_W  op identifier
- io_flush  in  1  abandon the in-flight op
- io_md_req_valid  out  1; io_md_req_ready  in  1
- io_md_req_bits_fn  out  4; io_md_req_bits_dw  out  1; io_md_req_bits_in1, io_md_req_bits_in2  out  64
- io_md_kill  out  1
- io_md_resp_ready  out  1; io_md_resp_valid  in  1; io_md_resp_bits_data  in  64
- io_out_valid / io_out_ready  out / in  1 / 1  downstream handshake
- io_out_bits_data  out  64; io_out_bits_tag  out  TAG_W; io_out_bits_cycles  out  CNT_W

## Operation
FSM states: IDLE, REQ, BUSY.
- **IDLE:** io_in_ready = !fifo_full & !io_flush. On accept, fn/dw/in1/in2/tag go into op registers, the counter resets to 0, and the FSM moves to REQ.
- **REQ:** io_md_req_valid = 1 and io_md_req_bits_* are driven from the op registers, held stable until io_md_req_ready. On req fire, the FSM moves to BUSY.
- **BUSY:** io_md_resp_ready = 1. On resp fire, {data, tag, counter} is enqueued and the FSM moves to IDLE.
- **Counter:** increments every cycle in REQ and BUSY. It saturates at 2^CNT_W−1 and never wraps. The enqueued value is the count at resp fire, i.e. cycles from accept to response.
- **Slot reservation:** an op is accepted only if a FIFO slot is free. Only the unit enqueues, so a response can always enqueue, and io_md_resp_ready never depends on io_out_ready.
- **Flush in REQ:** io_md_req_valid drops the same cycle, no kill is issued, and the FSM moves to IDLE.
- **Flush in BUSY:** io_md_kill = 1 that cycle and io_md_resp_ready = 0. A coincident response is discarded. The FSM moves to IDLE.
- **Flush in IDLE:** only blocks accept.
- **Flush and the FIFO:** flush never clears the FIFO; completed results remain.
- **FIFO:** enqueue and dequeue in the same cycle are both honoured. io_out_* come from the head entry. io_out_valid = !empty.
- **Mid-operation reset:** reset asserted mid-operation returns the FSM to IDLE and empties the FIFO. No kill pulse is generated, because MulDiv shares the reset.

## Timing
- **Reset values:** io_in_ready 0 while reset is asserted, 1 from the first cycle after release. io_md_req_valid, io_md_kill, io_md_resp_ready, and io_out_valid are 0. io_md_req_bits_* and io_out_bits_* are 0.
- **Accept to request:** an op accepted in cycle t has io_md_req_valid high in t+1.
- **Minimum round trip:** with req fire at t+1 and resp fire at t+1+L, the entry is visible on io_out in t+2+L, with cycles = L+1.
- **Combinational paths:** io_md_kill and io_md_resp_ready are combinational from io_flush and state. io_in_ready is combinational from io_flush. All other outputs are registered or derived from registers.
- **Throughput:** at most one op per (L+2) cycles; no overlapping requests.

## Structure
- **Package muldiv_issue_pkg:**
  - state enum {IDLE, REQ, BUSY}
  - MulDiv fn code constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
  - result entry struct {data, tag, cycles}
- **Sub-module muldiv_result_fifo:** parameterised on depth and entry width. Provides full/empty and pointer wrap on power-of-two depth.

## Test plan
- **Basic op:** fn=MUL, dw=1, in1=6, in2=7, tag=3, MulDiv resp 2 cycles after req fire → out data=42, tag=3, cycles=3, exactly one entry.
- **Request back-pressure:** io_md_req_ready low for 5 cycles → req_bits stable throughout, counter includes the stall, cycles = 5+L+1.
- **Flush in BUSY coincident with io_md_resp_valid:** → io_md_kill=1 and resp_ready=0 that cycle, no FIFO entry, io_in_ready=1 next cycle.
- **FIFO full:** hold io_out_ready=0 and complete 2 ops → io_in_ready stays 0 with the third op pending. Raise io_out_ready for 1 cycle → tag order preserved, third op accepted.
- **Saturation:** CNT_W=4, MulDiv resp delayed 40 cycles → cycles=15.
- **Mid-operation reset:** async reset in BUSY → same-cycle io_md_resp_ready=0, io_out_valid=0; after release the FSM is in IDLE and the FIFO is empty.
